// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared definitions for the CPU bus controller: bus widths, FSM state
// encodings and a small request-decode helper.
package cpu_bus_ctrl_pkg;

  localparam int CPU_DATA_MSB_POS     = 7;
  localparam int CPU_FAR_ADDR_MSB_POS = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bus_state_t;

  function automatic logic is_access(input logic re, input logic we);
    return re | we;
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// Core-side and memory-side signals of the bus controller, bundled with
// master (controller) and slave (core + memory environment) views.
interface cpu_bus_ctrl_if
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_FAR_ADDR_MSB_POS + 1,
  parameter int DATA_WIDTH = CPU_DATA_MSB_POS + 1
) ();

  logic                  cpu_re;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  cpu_enable;

  // Memory handshake: mem_req rises with mem_addr/mem_we/mem_wdata valid and
  // holds them stable until completion; mem_ack is a one-cycle strobe that is
  // only meaningful while mem_req=1 (mem_rdata valid with it on reads). The
  // controller may drop mem_req without an ack on timeout or reset.
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  bus_err;
  bus_state_t            dbg_state;

  modport master (
    input  cpu_re, cpu_we, cpu_addr, cpu_data_out, mem_rdata, mem_ack,
    output cpu_data_in, cpu_enable, mem_req, mem_we, mem_addr, mem_wdata,
           bus_err, dbg_state
  );

  modport slave (
    output cpu_re, cpu_we, cpu_addr, cpu_data_out, mem_rdata, mem_ack,
    input  cpu_data_in, cpu_enable, mem_req, mem_we, mem_addr, mem_wdata,
           bus_err, dbg_state
  );

endinterface

// File: rtl/cpu_bus_ctrl.sv
// Single-outstanding CPU-to-memory bus controller: stalls the core while a
// req/ack access runs, with timeout, open-bus read value and sticky error.
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = CPU_FAR_ADDR_MSB_POS + 1,
  parameter int DATA_WIDTH     = CPU_DATA_MSB_POS + 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst,
  cpu_bus_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] open_bus;
  logic                  err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      open_bus <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_access(bus.cpu_re, bus.cpu_we)) begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_data_out;
            we_q    <= bus.cpu_we;
            req_q   <= 1'b1;
            cnt     <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack in the final counted cycle still wins over the abort.
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_q  <= bus.mem_rdata;
              open_bus <= bus.mem_rdata;
            end
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= open_bus;
            end
            err_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The core stalls in the very cycle it raises a request.
  assign bus.cpu_enable = !rst &&
                          ((state == ST_DONE) ||
                           ((state == ST_IDLE) && !is_access(bus.cpu_re, bus.cpu_we)));

  assign bus.cpu_data_in = rdata_q;
  assign bus.mem_req     = req_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.bus_err     = err_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed and random accesses with a
// reference model of returned data and the sticky error flag.
module tb_cpu_bus_ctrl;
  import cpu_bus_ctrl_pkg::*;

  localparam int AW      = 24;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;

  cpu_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpu_bus_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];        // {bus_err, cpu_data_in} expected at each DONE
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_issued = 0;
  int          n_done = 0;
  int          n_rise = 0;
  logic        req_prev = 1'b0;
  logic [DW-1:0] model_data = '0;
  logic [DW-1:0] model_open = '0;
  logic          model_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per DONE pulse, count request launches.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req && !req_prev) n_rise++;
      if (bus.dbg_state == ST_DONE) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("cpu_data_in", 32'(bus.cpu_data_in), 32'(e[DW-1:0]));
          check("bus_err_done", 32'(bus.bus_err), 32'(e[DW]));
        end
      end
    end
    req_prev = bus.mem_req;
  end

  // ---------------- driver ----------------
  // ack_at: REQ cycle (1-based) in which to strobe mem_ack; 0 = never.
  task automatic access(input logic re, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int ack_at,
                        input logic [DW-1:0] rd, input logic hold,
                        input logic late_ack);
    int   req_cycles;
    int   exp_req;
    logic acked;
    logic done;
    acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
    exp_req = acked ? ack_at : TIMEOUT;
    if (!we) begin
      if (acked) begin
        model_data = rd;
        model_open = rd;
      end else begin
        model_data = model_open;
      end
    end
    if (!acked) model_err = 1'b1;
    exp_q.push_back({model_err, model_data});
    n_issued++;

    bus.cpu_re       = re;
    bus.cpu_we       = we;
    bus.cpu_addr     = addr;
    bus.cpu_data_out = wd;
    #1;
    check("enable_stall_c0", 32'(bus.cpu_enable), 32'd0);

    req_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < TIMEOUT + 4 && !done; c++) begin
      @(negedge clk);
      if (bus.dbg_state == ST_DONE) begin
        done = 1'b1;
      end else begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
          req_cycles++;
          check("mem_addr", 32'(bus.mem_addr), 32'(addr));
          check("mem_we", 32'(bus.mem_we), 32'(we));
          check("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
          check("enable_stall", 32'(bus.cpu_enable), 32'd0);
          if (req_cycles == ack_at) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
          end
        end
      end
    end
    bus.mem_ack = 1'b0;
    check("done_reached", 32'(done), 32'd1);
    check("req_cycles", 32'(req_cycles), 32'(exp_req));
    check("enable_done", 32'(bus.cpu_enable), 32'd1);
    check("req_low_done", 32'(bus.mem_req), 32'd0);
    if (!hold) begin
      bus.cpu_re = 1'b0;
      bus.cpu_we = 1'b0;
    end
    if (late_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h77;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle_after_done", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("data_hold_idle", 32'(bus.cpu_data_in), 32'(model_data));
    check("err_idle", 32'(bus.bus_err), 32'(model_err));
    if (!hold) check("req_low_idle", 32'(bus.mem_req), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data_out = '0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_data_in", 32'(bus.cpu_data_in), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check("rst_enable", 32'(bus.cpu_enable), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle_enable", 32'(bus.cpu_enable), 32'd1);

    // zero-wait read, wait-state write, boundary ack, timeout + late ack
    access(1'b1, 1'b0, 24'h12_3456, 8'h00, 1, 8'hA5, 1'b0, 1'b0);
    access(1'b0, 1'b1, 24'h00_0F00, 8'h3C, 5, 8'hEE, 1'b0, 1'b0);
    access(1'b1, 1'b0, 24'hFF_FFFF, 8'h00, TIMEOUT, 8'h5A, 1'b0, 1'b0);
    access(1'b1, 1'b0, 24'h80_0000, 8'h00, 0, 8'hC3, 1'b0, 1'b1);
    access(1'b1, 1'b0, 24'h00_0001, 8'h00, 2, 8'h11, 1'b0, 1'b0);
    // re and we together: write wins
    access(1'b1, 1'b1, 24'h44_5566, 8'hFF, 3, 8'h99, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      access(!w, w, AW'($urandom), DW'($urandom), $urandom_range(1, 6),
             DW'($urandom_range(1, 255)), 1'b0, 1'b0);
    end

    // re held across DONE: one access per pulse
    access(1'b1, 1'b0, 24'hAB_CDEF, 8'h00, 1, 8'h22, 1'b1, 1'b0);
    access(1'b1, 1'b0, 24'hAB_CDEF, 8'h00, 2, 8'h33, 1'b0, 1'b0);

    // reset during the 3rd REQ cycle
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = 24'h00_7777;
    repeat (3) @(negedge clk);
    check("mid_req_high", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_err", 32'(bus.bus_err), 32'd0);
    check("mid_rst_data", 32'(bus.cpu_data_in), 32'd0);
    check("mid_rst_enable", 32'(bus.cpu_enable), 32'd0);
    rst = 1'b0;
    bus.cpu_re = 1'b0;
    model_data = '0;
    model_open = '0;
    model_err  = 1'b0;
    @(negedge clk);
    access(1'b1, 1'b0, 24'h00_7777, 8'h00, 1, 8'h6D, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_issued));
    check("launch_count", 32'(n_rise), 32'(n_issued + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Sits directly downstream of the Cpu core.
- Consumes the core's re/we/addr/data_out and runs one access at a time on a req/ack memory port.
- Stalls the core through its enable input until the access completes, then returns read data on data_in.
- Provides a timeout with open-bus read value and a sticky error flag, so a missing slave cannot hang the core.

Parameters:
ADDR_WIDTH, 24, far address width (CPU_FAR_ADDR_MSB_POS+1)
DATA_WIDTH, 8, data width (CPU_DATA_MSB_POS+1)
TIMEOUT_CYCLES, 16, max cycles in REQ before abort (>=2)

Ports:
clk  input  1  single clock, all state on posedge
rst  input  1  synchronous, active-high reset
cpu_re  input  1  read request from core
cpu_we  input  1  write request from core
cpu_addr  input  ADDR_WIDTH  access address from core
cpu_data_out  input  DATA_WIDTH  write data from core
cpu_data_in  output  DATA_WIDTH  read data to core (registered)
cpu_enable  output  1  step enable to core (combinational)
mem_req  output  1  request to memory (registered)
mem_we  output  1  1=write, 0=read (registered)
mem_addr  output  ADDR_WIDTH  latched address (registered)
mem_wdata  output  DATA_WIDTH  latched write data (registered)
mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1
mem_ack  input  1  single-cycle completion strobe
bus_err  output  1  sticky timeout flag (registered)

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_data_in=0, open_bus=0, bus_err=0, timeout counter=0.
  - cpu_enable forced 0 while rst=1.
- cpu_enable = (state==DONE) | (state==IDLE & !cpu_re & !cpu_we). The core therefore stalls in the same cycle it presents a request.
- IDLE, on (cpu_re|cpu_we):
  - Latch cpu_addr into mem_addr and cpu_data_out into mem_wdata.
  - mem_we=cpu_we. If re and we are both 1, the write wins.
  - mem_req<=1, counter<=0, go to REQ.
- REQ:
  - mem_req is held at 1 and mem_addr/mem_we/mem_wdata are held stable. mem_ack is only meaningful while mem_req=1.
  - On mem_ack=1: mem_req<=0. If a read, cpu_data_in<=mem_rdata and open_bus<=mem_rdata. Go to DONE.
  - On mem_ack=0 with counter==TIMEOUT_CYCLES-1: mem_req<=0. If a read, cpu_data_in<=open_bus. bus_err<=1. Go to DONE.
  - Otherwise counter++.
  - An ack arriving in the timeout cycle takes precedence: the access completes normally and bus_err is not set.
- DONE:
  - cpu_enable=1 for exactly one cycle; the core consumes cpu_data_in and updates re/we/addr.
  - Next state is IDLE.
  - Request inputs are ignored in DONE, so a request held from before the step cannot be double-issued.
- Writes: cpu_data_in and open_bus are unchanged.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_req=1 from cycle 1.
  - Ack sampled at cycle k gives DONE and valid data at k+1, and IDLE at k+2.
  - A zero-wait ack (k=1) is 3 cycles per access.
- Timeout abort: mem_req deasserts for at least one cycle. A late mem_ack outside REQ is ignored.
- bus_err clears only on rst.
- rst mid-access: mem_req drops at that edge; the memory side must tolerate an abandoned request. The FSM returns to IDLE and the latched request is discarded.
- Counter width is $clog2(TIMEOUT_CYCLES) and never wraps (bounded by the abort).

Decomposition:
- Shared include (cpu_defines): CPU_DATA_MSB_POS, CPU_FAR_ADDR_MSB_POS, and bus FSM state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
- Single module; no sub-module is warranted. The timeout counter is a local register.

Test Plan:
- Zero-wait read: cpu_re=1, addr=24'h12_3456, ack on the first REQ cycle with rdata=8'hA5 -> mem_addr=24'h123456, mem_we=0; cpu_data_in=8'hA5 and cpu_enable=1 exactly at cycle 2; cpu_enable=0 in cycles 0-1.
- Wait-state write: cpu_we=1, data_out=8'h3C, ack after 5 REQ cycles -> mem_req high for 5 cycles, mem_wdata=8'h3C stable throughout; cpu_data_in unchanged.
- Timeout: read with no ack, TIMEOUT_CYCLES=16, previous read returned 8'h5A -> mem_req high for exactly 16 cycles; cpu_data_in=8'h5A; bus_err=1 and still 1 after a later good access.
- Boundary ack: ack in the 16th REQ cycle -> normal completion, bus_err stays 0. A late ack one cycle after abort -> ignored, no state change.
- Simultaneous re and we with data_out=8'hFF -> write issued (mem_we=1).
- Back-to-back requests with re held across DONE -> exactly one memory access per DONE pulse.
- rst asserted in the 3rd REQ cycle -> next edge: mem_req=0, bus_err=0, cpu_data_in=0, cpu_enable=0 while rst=1; after release, a fresh read completes normally.
